// File: rtl/packet_disassembler_if.sv
// Handshake bundle between a packet source, the disassembler and the downstream chunk sink.
// The slave modport is the disassembler's view; master is the surrounding driver's view.
interface packet_disassembler_if #(
  parameter int nbits       = 32,
  parameter int chunk_nbits = 8
);
  logic                   recv_val;
  logic                   recv_rdy;
  logic [nbits-1:0]       recv_msg;
  logic                   send_val;
  logic                   send_rdy;
  logic [chunk_nbits-1:0] send_msg;

  modport slave (
    input  recv_val, recv_msg, send_rdy,
    output recv_rdy, send_val, send_msg
  );

  modport master (
    output recv_val, recv_msg, send_rdy,
    input  recv_rdy, send_val, send_msg
  );
endinterface

// File: rtl/packet_disassembler.sv
// Captures one wide packet and emits it as a run of narrower chunks, MSB chunk first.
// Every output is decoded from registered state only.
module packet_disassembler #(
  parameter int nbits       = 32,
  parameter int chunk_nbits = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  packet_disassembler_if.slave  bus,
  output logic                  busy
);
  localparam int num_chunks = nbits / chunk_nbits;
  localparam int cnt_nbits  = $clog2(num_chunks);
  localparam logic [cnt_nbits-1:0] last_cnt = cnt_nbits'(num_chunks - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e               state_q, state_d;
  logic [cnt_nbits-1:0] cnt_q, cnt_d;
  logic [nbits-1:0]     pkt_q, pkt_d;
  logic [nbits-1:0]     shifted;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
    end
  end

  // The packet register is only loaded from IDLE, so new offers during SEND are ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pkt_d   = pkt_q;
    case (state_q)
      IDLE: begin
        if (bus.recv_val) begin
          state_d = SEND;
          cnt_d   = '0;
          pkt_d   = bus.recv_msg;
        end
      end
      SEND: begin
        if (bus.send_rdy) begin
          if (cnt_q == last_cnt) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shifting the current chunk up to the MSB end keeps the select index constant.
  always_comb begin
    shifted      = pkt_q << (32'(cnt_q) * chunk_nbits);
    bus.recv_rdy = (state_q == IDLE);
    bus.send_val = (state_q == SEND);
    busy         = (state_q == SEND);
    bus.send_msg = '0;
    if (state_q == SEND) begin
      bus.send_msg = shifted[nbits-1 -: chunk_nbits];
    end
  end
endmodule

// File: tb/tb_packet_disassembler.sv
// Self-checking bench for packet_disassembler: directed scenarios, a randomized run
// against a chunk-queue reference model, and a 64/16 parameterisation.
module tb_packet_disassembler;
  logic clk = 1'b0;
  logic reset;
  logic busy32, busy64;
  int   passCount = 0;
  int   checkCount = 0;

  always #5 clk = ~clk;

  packet_disassembler_if #(.nbits(32), .chunk_nbits(8))  bus32 ();
  packet_disassembler_if #(.nbits(64), .chunk_nbits(16)) bus64 ();

  packet_disassembler #(.nbits(32), .chunk_nbits(8)) dut32 (
    .clk(clk), .reset(reset), .bus(bus32.slave), .busy(busy32)
  );

  packet_disassembler #(.nbits(64), .chunk_nbits(16)) dut64 (
    .clk(clk), .reset(reset), .bus(bus64.slave), .busy(busy64)
  );

  // Chunk idx of a packet, counting from the most significant end.
  function automatic logic [63:0] refChunk(input logic [63:0] pkt, input int nb,
                                           input int cb, input int idx);
    return (pkt >> (nb - cb * (idx + 1))) & ((64'd1 << cb) - 64'd1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checkCount++;
    if (bus32.recv_rdy !== 1'b1) $display("[TB] FAIL reset_recv_rdy: got %b expected 1", bus32.recv_rdy);
    else passCount++;
    checkCount++;
    if (bus32.send_val !== 1'b0) $display("[TB] FAIL reset_send_val: got %b expected 0", bus32.send_val);
    else passCount++;
    checkCount++;
    if (busy32 !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy32);
    else passCount++;
    checkCount++;
    if (bus32.send_msg !== 8'h00) $display("[TB] FAIL reset_send_msg: got %h expected 00", bus32.send_msg);
    else passCount++;
    checkCount++;
    if (bus64.send_val !== 1'b0 || bus64.recv_rdy !== 1'b1)
      $display("[TB] FAIL reset_64: got val=%b rdy=%b expected val=0 rdy=1", bus64.send_val, bus64.recv_rdy);
    else passCount++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] exp8;
    bus32.recv_msg = 32'hDEADBEEF;
    bus32.recv_val = 1'b1;
    bus32.send_rdy = 1'b1;
    step();
    bus32.recv_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp8 = 8'(refChunk(64'hDEADBEEF, 32, 8, i));
      checkCount++;
      if (bus32.send_msg !== exp8) $display("[TB] FAIL basic_msg[%0d]: got %h expected %h", i, bus32.send_msg, exp8);
      else passCount++;
      checkCount++;
      if (bus32.send_val !== 1'b1 || bus32.recv_rdy !== 1'b0 || busy32 !== 1'b1)
        $display("[TB] FAIL basic_flags[%0d]: got val=%b rdy=%b busy=%b expected 1 0 1",
                 i, bus32.send_val, bus32.recv_rdy, busy32);
      else passCount++;
      step();
    end
    checkCount++;
    if (bus32.recv_rdy !== 1'b1 || bus32.send_val !== 1'b0 || bus32.send_msg !== 8'h00)
      $display("[TB] FAIL basic_idle: got rdy=%b val=%b msg=%h expected 1 0 00",
               bus32.recv_rdy, bus32.send_val, bus32.send_msg);
    else passCount++;
  endtask

  task automatic test_backpressure();
    bus32.recv_msg = 32'hDEADBEEF;
    bus32.recv_val = 1'b1;
    bus32.send_rdy = 1'b1;
    step();
    bus32.recv_val = 1'b0;
    checkCount++;
    if (bus32.send_msg !== 8'hDE) $display("[TB] FAIL bp_first: got %h expected de", bus32.send_msg);
    else passCount++;
    step();
    bus32.send_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkCount++;
      if (bus32.send_msg !== 8'hAD || bus32.send_val !== 1'b1)
        $display("[TB] FAIL bp_hold[%0d]: got msg=%h val=%b expected ad 1", i, bus32.send_msg, bus32.send_val);
      else passCount++;
      if (i < 3) step();
    end
    bus32.send_rdy = 1'b1;
    step();
    checkCount++;
    if (bus32.send_msg !== 8'hBE) $display("[TB] FAIL bp_third: got %h expected be", bus32.send_msg);
    else passCount++;
    step();
    checkCount++;
    if (bus32.send_msg !== 8'hEF || bus32.send_val !== 1'b1)
      $display("[TB] FAIL bp_fourth: got msg=%h val=%b expected ef 1", bus32.send_msg, bus32.send_val);
    else passCount++;
    step();
    checkCount++;
    if (bus32.recv_rdy !== 1'b1) $display("[TB] FAIL bp_idle: got %b expected 1", bus32.recv_rdy);
    else passCount++;
  endtask

  task automatic test_ignore_busy();
    logic [7:0] exp8;
    bus32.recv_msg = 32'h12345678;
    bus32.recv_val = 1'b1;
    bus32.send_rdy = 1'b1;
    step();
    bus32.recv_msg = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      exp8 = 8'(refChunk(64'h12345678, 32, 8, i));
      checkCount++;
      if (bus32.send_msg !== exp8) $display("[TB] FAIL ignore_msg[%0d]: got %h expected %h", i, bus32.send_msg, exp8);
      else passCount++;
      step();
    end
    checkCount++;
    if (bus32.recv_rdy !== 1'b1 || bus32.send_val !== 1'b0)
      $display("[TB] FAIL ignore_gap: got rdy=%b val=%b expected 1 0", bus32.recv_rdy, bus32.send_val);
    else passCount++;
    step();
    bus32.recv_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkCount++;
      if (bus32.send_msg !== 8'hFF || bus32.send_val !== 1'b1)
        $display("[TB] FAIL ignore_second[%0d]: got msg=%h val=%b expected ff 1", i, bus32.send_msg, bus32.send_val);
      else passCount++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pkts [2];
    logic [7:0]  exp8;
    pkts[0] = 32'h01020304;
    pkts[1] = 32'hA0B0C0D0;
    bus32.send_rdy = 1'b1;
    bus32.recv_val = 1'b1;
    bus32.recv_msg = pkts[0];
    step();
    bus32.recv_msg = pkts[1];
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        exp8 = 8'(refChunk(64'(pkts[p]), 32, 8, i));
        checkCount++;
        if (bus32.send_msg !== exp8 || bus32.send_val !== 1'b1)
          $display("[TB] FAIL b2b_msg[%0d][%0d]: got msg=%h val=%b expected %h 1",
                   p, i, bus32.send_msg, bus32.send_val, exp8);
        else passCount++;
        step();
      end
      checkCount++;
      if (bus32.send_val !== 1'b0 || bus32.recv_rdy !== 1'b1)
        $display("[TB] FAIL b2b_gap[%0d]: got val=%b rdy=%b expected 0 1", p, bus32.send_val, bus32.recv_rdy);
      else passCount++;
      if (p == 0) step();
      else bus32.recv_val = 1'b0;
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus32.recv_msg = 32'hDEADBEEF;
    bus32.recv_val = 1'b1;
    bus32.send_rdy = 1'b1;
    step();
    bus32.recv_val = 1'b0;
    checkCount++;
    if (bus32.send_msg !== 8'hDE) $display("[TB] FAIL rstmid_first: got %h expected de", bus32.send_msg);
    else passCount++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkCount++;
    if (bus32.send_val !== 1'b0 || busy32 !== 1'b0 || bus32.recv_rdy !== 1'b1 || bus32.send_msg !== 8'h00)
      $display("[TB] FAIL rstmid_abort: got val=%b busy=%b rdy=%b msg=%h expected 0 0 1 00",
               bus32.send_val, busy32, bus32.recv_rdy, bus32.send_msg);
    else passCount++;
    for (int i = 0; i < 4; i++) begin
      step();
      checkCount++;
      if (bus32.send_val !== 1'b0 || bus32.send_msg === 8'hAD)
        $display("[TB] FAIL rstmid_quiet[%0d]: got val=%b msg=%h expected val=0 and no ad",
                 i, bus32.send_val, bus32.send_msg);
      else passCount++;
    end
  endtask

  // Reference: accepted packets expand into a queue of expected chunks.
  task automatic test_random();
    logic [7:0] expQ [$];
    logic [7:0] exp8;
    logic       expBusy;
    for (int c = 0; c < 400; c++) begin
      expBusy = (expQ.size() != 0);
      exp8    = expBusy ? expQ[0] : 8'h00;
      checkCount++;
      if (bus32.send_val !== expBusy || bus32.recv_rdy !== !expBusy || busy32 !== expBusy)
        $display("[TB] FAIL rand_flags@%0d: got val=%b rdy=%b busy=%b expected busy=%b",
                 c, bus32.send_val, bus32.recv_rdy, busy32, expBusy);
      else passCount++;
      checkCount++;
      if (bus32.send_msg !== exp8) $display("[TB] FAIL rand_msg@%0d: got %h expected %h", c, bus32.send_msg, exp8);
      else passCount++;
      bus32.recv_val = 1'($urandom_range(0, 1));
      bus32.recv_msg = $urandom;
      bus32.send_rdy = ($urandom_range(0, 3) != 0);
      if (!expBusy && bus32.recv_val) begin
        for (int i = 0; i < 4; i++) expQ.push_back(8'(refChunk(64'(bus32.recv_msg), 32, 8, i)));
      end else if (expBusy && bus32.send_rdy) begin
        void'(expQ.pop_front());
      end
      step();
    end
    bus32.recv_val = 1'b0;
    bus32.send_rdy = 1'b1;
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_param64();
    logic [15:0] exp16;
    bus64.recv_msg = 64'h0123456789ABCDEF;
    bus64.recv_val = 1'b1;
    bus64.send_rdy = 1'b1;
    step();
    bus64.recv_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp16 = 16'(refChunk(64'h0123456789ABCDEF, 64, 16, i));
      checkCount++;
      if (bus64.send_msg !== exp16 || bus64.send_val !== 1'b1)
        $display("[TB] FAIL p64_msg[%0d]: got msg=%h val=%b expected %h 1", i, bus64.send_msg, bus64.send_val, exp16);
      else passCount++;
      step();
    end
    checkCount++;
    if (bus64.recv_rdy !== 1'b1 || bus64.send_val !== 1'b0)
      $display("[TB] FAIL p64_idle: got rdy=%b val=%b expected 1 0", bus64.recv_rdy, bus64.send_val);
    else passCount++;
  endtask

  initial begin
    reset = 1'b0;
    bus32.recv_val = 1'b0;
    bus32.recv_msg = '0;
    bus32.send_rdy = 1'b0;
    bus64.recv_val = 1'b0;
    bus64.recv_msg = '0;
    bus64.send_rdy = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_param64();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
